// File: rtl/hex_word_entry.sv
// Debounced pushbutton entry of 16-bit words, one hex nibble per accepted press; registered outputs.
// A completed word holds wr_en/wr_data/wr_addr until wr_ready; presses arriving meanwhile are dropped.
module hex_word_entry #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        button,
  input  logic [3:0]  switch,
  input  logic        enable,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [15:0] preview,
  output logic [1:0]  nib_idx
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic {COLLECT, WRITE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press;
  logic [15:0]   addr_nxt, data_nxt, prev_nxt, shifted;
  logic [1:0]    idx_nxt;

  // Pulse fires only on the step into saturation, so a held button yields one press.
  always_comb begin
    cnt_nxt = cnt;
    if (!button)
      cnt_nxt = '0;
    else if (cnt != CNT_MAX)
      cnt_nxt = cnt + 1'b1;
    press = button && (cnt == CNT_MAX - 1'b1);
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = wr_addr;
    data_nxt  = wr_data;
    prev_nxt  = preview;
    idx_nxt   = nib_idx;
    shifted   = {preview[11:0], switch};
    case (state)
      COLLECT: begin
        if (!enable) begin
          prev_nxt = '0;
          idx_nxt  = '0;
        end else if (press) begin
          prev_nxt = shifted;
          if (nib_idx == 2'd3) begin
            data_nxt  = shifted;
            state_nxt = WRITE;
          end else begin
            idx_nxt = nib_idx + 2'd1;
          end
        end
      end
      WRITE: begin
        if (wr_ready) begin
          state_nxt = COLLECT;
          addr_nxt  = wr_addr + 16'd1;
          prev_nxt  = '0;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= COLLECT;
      cnt     <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      preview <= '0;
      nib_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_addr <= addr_nxt;
      wr_data <= data_nxt;
      preview <= prev_nxt;
      nib_idx <= idx_nxt;
    end
  end

  // The state flop itself is the write request.
  assign wr_en = (state == WRITE);

endmodule

// File: doc/hex_word_entry.md
HEX_WORD_ENTRY -- requirements
Module: hex_word_entry

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 100000, number of consecutive clk cycles button must read high before a press is accepted.
REQ-002 Port: clk  input  1  system clock; all state updates on posedge clk.
REQ-003 Port: clr  input  1  reset; synchronous, active-high; one clock, no other clock domains.
REQ-004 Port: button  input  1  raw, undebounced pushbutton (high = pressed).
REQ-005 Port: switch  input  4  hex nibble to enter on each accepted press.
REQ-006 Port: enable  input  1  entry mode enable; low = presses ignored and partial word discarded.
REQ-007 Port: wr_ready  input  1  memory side accepts the pending write this cycle.
REQ-008 Port: wr_en  output  1  write request to instruction/data memory.
REQ-009 Port: wr_addr  output  16  target word address of the pending or next write.
REQ-010 Port: wr_data  output  16  assembled word, valid while wr_en high.
REQ-011 Port: preview  output  16  partially assembled word for the seven-segment display.
REQ-012 Port: nib_idx  output  2  number of nibbles entered in the current word (0-3).

Function
REQ-013 Debounce counter: saturating, increments each cycle button=1 up to DEBOUNCE_CYCLES; clears to 0 on any cycle button=0.
REQ-014 Accepted press: one-cycle internal pulse, exactly on the cycle the counter transitions to DEBOUNCE_CYCLES; holding button produces no further pulses until release and re-press.
REQ-015 FSM states: COLLECT (gathering nibbles) and WRITE (word pending); reset state COLLECT.
REQ-016 COLLECT, pulse and enable=1 and nib_idx<3: preview <= {preview[11:0], switch}; nib_idx <= nib_idx+1.
REQ-017 COLLECT, pulse and enable=1 and nib_idx=3: wr_data <= {preview[11:0], switch}; preview <= same value; go to WRITE; wr_en=1 from next cycle.
REQ-018 WRITE: wr_en held 1 and wr_data, wr_addr held stable until a cycle with wr_ready=1.
REQ-019 Handshake completes on a cycle with wr_en=1 and wr_ready=1; next cycle: wr_en=0, wr_addr+1, preview=0, nib_idx=0, state COLLECT.
REQ-020 wr_addr increments modulo 2^16; 0xFFFF wraps to 0x0000.
REQ-021 Pulses arriving in WRITE are discarded (not queued); debounce counter still runs.
REQ-022 enable=0 in COLLECT: preview and nib_idx cleared next cycle; pulses ignored.
REQ-023 enable=0 in WRITE: pending write not aborted; completes per REQ-019.
REQ-024 wr_ready ignored while wr_en=0.
REQ-025 wr_en is a registered output; no combinational path from any input to any output.

Reset
REQ-026 clr=1 at a posedge: state=COLLECT, wr_en=0, wr_addr=0x0000, wr_data=0x0000, preview=0x0000, nib_idx=0, debounce counter=0.
REQ-027 clr has priority over every other input, including mid-word and mid-WRITE (pending write dropped, no further wr_en).
REQ-028 A button held through clr deassertion counts from 0 and yields one press after DEBOUNCE_CYCLES cycles.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 enable=1, presses with switch=1,2,3,4, wr_ready=1 -> preview 0x0001,0x0012,0x0123; wr_en one cycle with wr_data=0x1234, wr_addr=0x0000; then wr_addr=0x0001, preview=0.
REQ-030 button high 3 cycles then low -> no nibble accepted; button high 20 cycles -> exactly one nibble accepted.
REQ-031 Complete word with wr_ready=0 for 10 cycles plus two extra presses -> wr_en stays 1, wr_data unchanged, extra presses lost; wr_ready=1 -> single write, nib_idx=0.
REQ-032 Enter 2 nibbles (0xA,0xB), drop enable 1 cycle, re-enable, enter 0x1,0x2,0x3,0x4 -> wr_data=0x1234.
REQ-033 wr_addr preloaded to 0xFFFF via 65535 completed writes (or forced) -> next completed write uses 0xFFFF, then wr_addr=0x0000.
REQ-034 clr=1 while wr_en=1 and wr_ready=0 -> next cycle wr_en=0, all outputs at reset values.
